// File: rtl/exc_pkg.sv
// Shared constants and types for the exception commit controller: exccodes,
// vector addresses, FSM encoding and the flag bundle fed to the priority encoder.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_e;

    typedef enum logic [1:0] {
        BV_NONE = 2'd0,
        BV_PC   = 2'd1,
        BV_DATA = 2'd2
    } badv_sel_e;

    typedef struct packed {
        logic adel_if;
        logic ri;
        logic ov;
        logic sys;
        logic bp;
        logic adel_d;
        logic ades_d;
    } exc_flags_t;

    // EPC points at the branch when the faulting instruction sits in its delay slot.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: interrupt and exception flags to a single
// (valid, exccode, BadVAddr source) selection.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       int_pending_i,
    input  exc_flags_t flags_i,
    output logic       valid_o,
    output logic [4:0] exccode_o,
    output badv_sel_e  badv_sel_o
);

    always_comb begin
        valid_o    = 1'b1;
        exccode_o  = EXC_INT;
        badv_sel_o = BV_NONE;
        if (int_pending_i) begin
            exccode_o = EXC_INT;
        end else if (flags_i.adel_if) begin
            exccode_o  = EXC_ADEL;
            badv_sel_o = BV_PC;
        end else if (flags_i.ri) begin
            exccode_o = EXC_RI;
        end else if (flags_i.ov) begin
            exccode_o = EXC_OV;
        end else if (flags_i.sys) begin
            exccode_o = EXC_SYS;
        end else if (flags_i.bp) begin
            exccode_o = EXC_BP;
        end else if (flags_i.adel_d) begin
            exccode_o  = EXC_ADEL;
            badv_sel_o = BV_DATA;
        end else if (flags_i.ades_d) begin
            exccode_o  = EXC_ADES;
            badv_sel_o = BV_DATA;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception commit controller: prioritises the commit-slot exception, drives the
// CP0 update / ERET EXL-clear, then flushes and redirects fetch. Optional EXC_PERF_CNT_EN.
//
// state       | meaning
// ST_IDLE     | accepting commit slot; trap/ERET handled combinationally here
// ST_FLUSH    | one-cycle flush of younger stages
// ST_REDIRECT | redirect_valid held until fetch accepts
module exc_commit_ctrl
    import exc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic        in_in_delay_slot,
    input  logic        in_exc_adel_if,
    input  logic        in_exc_ri,
    input  logic        in_exc_ov,
    input  logic        in_exc_sys,
    input  logic        in_exc_bp,
    input  logic        in_exc_adel_d,
    input  logic        in_exc_ades_d,
    input  logic        in_eret,
    input  logic [31:0] in_data_vaddr,
    input  logic        cp0_int_pending,
    input  logic [31:0] cp0_epc,
    output logic        cp0_update_ena,
    output logic [4:0]  cp0_exccode,
    output logic        cp0_bd,
    output logic        cp0_exl,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_badvaddr_ena,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_cls_exl,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
`ifdef EXC_PERF_CNT_EN
    ,
    output logic [31:0] exc_count
`endif
);

    exc_state_e  state_q;
    logic        flush_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    exc_flags_t  flags;
    logic        enc_valid;
    logic [4:0]  enc_exccode;
    badv_sel_e   enc_badv_sel;
    logic        accept;
    logic        trap_take;
    logic        eret_take;

    assign flags = '{adel_if: in_exc_adel_if, ri: in_exc_ri, ov: in_exc_ov,
                     sys: in_exc_sys, bp: in_exc_bp, adel_d: in_exc_adel_d,
                     ades_d: in_exc_ades_d};

    exc_prio_enc u_prio_enc (
        .int_pending_i (cp0_int_pending),
        .flags_i       (flags),
        .valid_o       (enc_valid),
        .exccode_o     (enc_exccode),
        .badv_sel_o    (enc_badv_sel)
    );

    // Combinational CP0 strobes are masked during reset so every output reads 0.
    assign accept    = (state_q == ST_IDLE) && !rst;
    assign trap_take = accept && in_valid && enc_valid;
    assign eret_take = accept && in_valid && in_eret && !enc_valid;

    assign in_ready         = accept;
    assign cp0_update_ena   = trap_take;
    assign cp0_exl          = trap_take;
    assign cp0_exccode      = trap_take ? enc_exccode : 5'd0;
    assign cp0_bd           = trap_take && in_in_delay_slot;
    assign cp0_epc_o        = trap_take ? epc_of(in_pc, in_in_delay_slot) : 32'd0;
    assign cp0_badvaddr_ena = trap_take && (enc_badv_sel != BV_NONE);
    assign cp0_badvaddr     = !trap_take                ? 32'd0 :
                              (enc_badv_sel == BV_PC)   ? in_pc :
                              (enc_badv_sel == BV_DATA) ? in_data_vaddr : 32'd0;
    assign cp0_cls_exl      = eret_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trap_take) begin
                        redirect_pc_q <= EXC_VECTOR;
                        flush_q       <= 1'b1;
                        state_q       <= ST_FLUSH;
                    end else if (eret_take) begin
                        redirect_pc_q <= cp0_epc;
                        flush_q       <= 1'b1;
                        state_q       <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    flush_q          <= 1'b0;
                    redirect_valid_q <= 1'b1;
                    state_q          <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid_q <= 1'b0;
                        state_q          <= ST_IDLE;
                    end
                end
                default: begin
                    flush_q          <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    state_q          <= ST_IDLE;
                end
            endcase
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef EXC_PERF_CNT_EN
    logic [31:0] exc_count_q;
    logic [31:0] exc_count_d;

    assign exc_count_d = cp0_update_ena ? (exc_count_q + 32'd1) : exc_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_count_q <= 32'd0;
        end else begin
            exc_count_q <= exc_count_d;
        end
    end

    assign exc_count = exc_count_q;
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl; expected values are hand-computed constants.
// Build with +define+EXC_PERF_CNT_EN to also check the exception counter.
module tb_exc_commit_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_in_delay_slot;
    logic        in_exc_adel_if, in_exc_ri, in_exc_ov, in_exc_sys, in_exc_bp;
    logic        in_exc_adel_d, in_exc_ades_d, in_eret;
    logic [31:0] in_data_vaddr;
    logic        cp0_int_pending;
    logic [31:0] cp0_epc;
    logic        cp0_update_ena;
    logic [4:0]  cp0_exccode;
    logic        cp0_bd, cp0_exl;
    logic [31:0] cp0_epc_o;
    logic        cp0_badvaddr_ena;
    logic [31:0] cp0_badvaddr;
    logic        cp0_cls_exl;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
`ifdef EXC_PERF_CNT_EN
    logic [31:0] exc_count;
`endif

    int total = 0;
    int bad   = 0;

    exc_commit_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_pc            (in_pc),
        .in_in_delay_slot (in_in_delay_slot),
        .in_exc_adel_if   (in_exc_adel_if),
        .in_exc_ri        (in_exc_ri),
        .in_exc_ov        (in_exc_ov),
        .in_exc_sys       (in_exc_sys),
        .in_exc_bp        (in_exc_bp),
        .in_exc_adel_d    (in_exc_adel_d),
        .in_exc_ades_d    (in_exc_ades_d),
        .in_eret          (in_eret),
        .in_data_vaddr    (in_data_vaddr),
        .cp0_int_pending  (cp0_int_pending),
        .cp0_epc          (cp0_epc),
        .cp0_update_ena   (cp0_update_ena),
        .cp0_exccode      (cp0_exccode),
        .cp0_bd           (cp0_bd),
        .cp0_exl          (cp0_exl),
        .cp0_epc_o        (cp0_epc_o),
        .cp0_badvaddr_ena (cp0_badvaddr_ena),
        .cp0_badvaddr     (cp0_badvaddr),
        .cp0_cls_exl      (cp0_cls_exl),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ready   (redirect_ready)
`ifdef EXC_PERF_CNT_EN
        ,
        .exc_count        (exc_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        in_valid = 0; in_pc = 0; in_in_delay_slot = 0;
        in_exc_adel_if = 0; in_exc_ri = 0; in_exc_ov = 0; in_exc_sys = 0;
        in_exc_bp = 0; in_exc_adel_d = 0; in_exc_ades_d = 0; in_eret = 0;
        in_data_vaddr = 0; cp0_int_pending = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after the accepting edge: checks flush pulse, redirect hold and return to IDLE.
    task automatic finish_seq(input string tag, input logic [31:0] exp_pc, input int hold);
        clear_in();
        chk({tag, ".flush"}, flush, 1);
        chk({tag, ".rdy_flush"}, in_ready, 0);
        chk({tag, ".upd_flush"}, cp0_update_ena, 0);
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        chk({tag, ".flush_off"}, flush, 0);
        chk({tag, ".rv"}, redirect_valid, 1);
        chk({tag, ".rpc"}, redirect_pc, exp_pc);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".rv_hold"}, redirect_valid, 1);
            chk({tag, ".rpc_hold"}, redirect_pc, exp_pc);
            chk({tag, ".rdy_hold"}, in_ready, 0);
        end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        chk({tag, ".rv_done"}, redirect_valid, 0);
        chk({tag, ".rdy_done"}, in_ready, 1);
        chk({tag, ".flush_done"}, flush, 0);
    endtask

    initial begin
        clear_in();
        cp0_epc = 0;
        redirect_ready = 0;
        rst = 1;
        tick();
        tick();
        chk("rst.in_ready", in_ready, 0);
        chk("rst.flush", flush, 0);
        chk("rst.rv", redirect_valid, 0);
        chk("rst.rpc", redirect_pc, 0);
        rst = 0;
        #1;
        chk("idle.in_ready", in_ready, 1);
        chk("idle.upd", cp0_update_ena, 0);
`ifdef EXC_PERF_CNT_EN
        chk("rst.cnt", exc_count, 0);
`endif

        // Syscall, no delay slot
        in_valid = 1; in_pc = 32'hBFC0_0100; in_exc_sys = 1;
        #1;
        chk("sys.upd", cp0_update_ena, 1);
        chk("sys.code", cp0_exccode, 5'h08);
        chk("sys.epc", cp0_epc_o, 32'hBFC0_0100);
        chk("sys.bd", cp0_bd, 0);
        chk("sys.exl", cp0_exl, 1);
        chk("sys.bva_en", cp0_badvaddr_ena, 0);
        chk("sys.cls", cp0_cls_exl, 0);
        tick();
        finish_seq("sys", 32'hBFC0_0380, 0);
`ifdef EXC_PERF_CNT_EN
        chk("sys.cnt", exc_count, 1);
`endif

        // Overflow in a delay slot
        in_valid = 1; in_pc = 32'h8000_0010; in_in_delay_slot = 1; in_exc_ov = 1;
        #1;
        chk("ov.code", cp0_exccode, 5'h0C);
        chk("ov.bd", cp0_bd, 1);
        chk("ov.epc", cp0_epc_o, 32'h8000_000C);
        tick();
        finish_seq("ov", 32'hBFC0_0380, 1);

        // Interrupt beats store address error
        in_valid = 1; in_pc = 32'h8000_0040; in_exc_ades_d = 1;
        in_data_vaddr = 32'h1234_5671; cp0_int_pending = 1;
        #1;
        chk("int.code", cp0_exccode, 5'h00);
        chk("int.bva_en", cp0_badvaddr_ena, 0);
        chk("int.upd", cp0_update_ena, 1);
        tick();
        finish_seq("int", 32'hBFC0_0380, 0);

        // Store address error alone
        in_valid = 1; in_pc = 32'h8000_0044; in_exc_ades_d = 1; in_data_vaddr = 32'h1234_5671;
        #1;
        chk("ades.code", cp0_exccode, 5'h05);
        chk("ades.bva_en", cp0_badvaddr_ena, 1);
        chk("ades.bva", cp0_badvaddr, 32'h1234_5671);
        tick();
        finish_seq("ades", 32'hBFC0_0380, 0);

        // Fetch address error beats RI, BadVAddr is the PC
        in_valid = 1; in_pc = 32'h8000_0003; in_exc_adel_if = 1; in_exc_ri = 1;
        in_data_vaddr = 32'hDEAD_BEEF;
        #1;
        chk("adelif.code", cp0_exccode, 5'h04);
        chk("adelif.bva", cp0_badvaddr, 32'h8000_0003);
        chk("adelif.bva_en", cp0_badvaddr_ena, 1);
        tick();
        finish_seq("adelif", 32'hBFC0_0380, 0);

        // Break at pc 0 in a delay slot: EPC wraps
        in_valid = 1; in_pc = 32'h0; in_in_delay_slot = 1; in_exc_bp = 1;
        #1;
        chk("bp.code", cp0_exccode, 5'h09);
        chk("bp.epc", cp0_epc_o, 32'hFFFF_FFFC);
        tick();
        finish_seq("bp", 32'hBFC0_0380, 0);

        // Interrupt with no valid instruction is not taken
        cp0_int_pending = 1;
        #1;
        chk("intnv.upd", cp0_update_ena, 0);
        tick();
        chk("intnv.flush", flush, 0);
        chk("intnv.rdy", in_ready, 1);
        clear_in();

        // ERET with a held-off redirect
        in_valid = 1; in_eret = 1; cp0_epc = 32'h8000_2000;
        #1;
        chk("eret.cls", cp0_cls_exl, 1);
        chk("eret.upd", cp0_update_ena, 0);
        tick();
        cp0_epc = 32'h0;
        finish_seq("eret", 32'h8000_2000, 5);

        // ERET carrying syscall is a trap
        in_valid = 1; in_eret = 1; in_exc_sys = 1; in_pc = 32'h8000_0100; cp0_epc = 32'h8000_3000;
        #1;
        chk("eretsys.cls", cp0_cls_exl, 0);
        chk("eretsys.upd", cp0_update_ena, 1);
        chk("eretsys.code", cp0_exccode, 5'h08);
        tick();
        finish_seq("eretsys", 32'hBFC0_0380, 0);
`ifdef EXC_PERF_CNT_EN
        chk("cnt", exc_count, 7);
`endif

        // Reset while in REDIRECT
        in_valid = 1; in_pc = 32'h8000_0200; in_exc_ri = 1;
        tick();
        clear_in();
        tick();
        chk("rstr.rv_pre", redirect_valid, 1);
        rst = 1;
        tick();
        chk("rstr.rv", redirect_valid, 0);
        chk("rstr.rpc", redirect_pc, 0);
        chk("rstr.flush", flush, 0);
        chk("rstr.rdy", in_ready, 0);
`ifdef EXC_PERF_CNT_EN
        chk("rstr.cnt", exc_count, 0);
`endif
        rst = 0;
        #1;
        chk("rstr.idle", in_ready, 1);
        tick();
        chk("rstr.no_rv", redirect_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
